nano_imem: RTL
==============

# nano_imem

Instruction-fetch responder for the nano_riscv core: the memory end of the fetch interface. It accepts one fetch address at a time over a valid/ready request channel and returns the 32-bit instruction word, or an error, over a valid/ready response channel. A side write port lets a bench or boot loader fill the array before or during execution.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; power of two, 4..4096.
- LATENCY, 1: wait states inserted between request acceptance and response; range 0..15.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_req_valid  in  1  fetch request present.
- o_req_ready  out  1  block can accept a request.
- i_req_addr  in  32  byte address of the instruction.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  core accepts the response.
- o_rsp_inst  out  32  instruction word; NOP on error.
- o_rsp_err  out  1  misaligned or out-of-range fetch.
- i_wr_en  in  1  loader write strobe.
- i_wr_addr  in  32  loader byte address; bits [1:0] are ignored.
- i_wr_data  in  32  loader data.

## Operation
- FSM states:
  - IDLE: o_req_ready=1. A request is accepted when i_req_valid && o_req_ready; the address is latched and the wait counter is loaded with LATENCY. The next state is WAIT if LATENCY>0, otherwise RESP.
  - WAIT: counter decrements each cycle; at 1, go to RESP.
  - RESP: o_rsp_valid=1. Leave for IDLE on i_rsp_ready.
- Only one request is outstanding at a time. o_req_ready is 0 in WAIT and RESP.
- Word index = addr[AW+1:2], where AW = $clog2(DEPTH).
- Error conditions: addr[1:0]!=0, or addr[31:2] >= DEPTH. On error, o_rsp_err=1 and o_rsp_inst=32'h0000_0013 (NOP).
- Array read: data is registered on the transition into RESP. A same-word write in that same cycle returns the old data (read-before-write).
- Writes: the write port is active in every state and takes effect at the edge. Writes with an out-of-range index are dropped silently.

## Timing
- Reset values: o_req_ready=0, o_rsp_valid=0, o_rsp_inst=0, o_rsp_err=0, state IDLE. Array contents are not reset.
- o_req_ready rises at the first rising edge after i_rst_n deasserts.
- Latency: with acceptance at edge N, o_rsp_valid rises after edge N+1+LATENCY.
- Throughput: at most one fetch per LATENCY+2 cycles.
- Response hold: o_rsp_inst and o_rsp_err stay stable while o_rsp_valid && !i_rsp_ready.
- Reset assertion mid-transaction: immediate return to the reset values; the pending request is discarded.
- Request signals are ignored outside IDLE. i_req_valid may drop without acceptance.

## Configuration
- Macro: NANO_IMEM_WAIT_EN.
- Defined: LATENCY wait states apply as specified above.
- Undefined: the counter and WAIT state are compiled out. Every accepted request goes straight to RESP, so there is a fixed 1-cycle latency and LATENCY is ignored.

## Structure
- The shared package nano_pkg holds:
  - the NOP constant 32'h0000_0013;
  - the imem state enum {IDLE, WAIT, RESP};
  - the fetch width constant 32.
- Sub-module nano_imem_ram: DEPTH×32 array with one synchronous write port and one synchronous read port with read-before-write behaviour. nano_imem holds the FSM, counter, error check and output registers.

## Test plan
- Load word 0 = 32'h0010_0093 and word 1 = 32'h0020_0113; fetch 0x0 then 0x4 with i_rsp_ready=1 -> responses 0x00100093 then 0x00200113, err=0, each LATENCY+1 cycles after acceptance.
- Fetch 0x2 -> o_rsp_err=1, o_rsp_inst=0x00000013. Fetch 0x400 with DEPTH=256 -> the same error response.
- Hold i_rsp_ready=0 for 5 cycles after response valid -> o_rsp_valid, inst and err stable. o_req_ready=0 throughout; a request presented during this time is ignored.
- Write word 3 = 0xDEADBEEF in the RESP-entry cycle of a fetch of 0xC -> the old value is returned; a refetch returns 0xDEADBEEF.
- Assert i_rst_n=0 during WAIT -> all outputs go to their reset values immediately. After release, o_req_ready=1 one edge later and no stale response appears.
- Build without NANO_IMEM_WAIT_EN and with LATENCY=3 -> response valid exactly 1 cycle after acceptance.

Source files
------------

// File: rtl/nano_pkg.sv
// nano_pkg: shared definitions for the nano_riscv memory-side blocks.
//   FETCH_W      - instruction fetch width in bits
//   NOP_INST     - instruction returned on a faulting fetch (addi x0, x0, 0)
//   imem_state_e - instruction memory responder states
package nano_pkg;

    localparam int FETCH_W = 32;

    localparam logic [FETCH_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

endpackage

// File: rtl/nano_imem_ram.sv
// nano_imem_ram: DEPTH x FETCH_W instruction array.
//   One synchronous write port and one synchronous read port. A read and a
//   write to the same word on the same edge return the old word.
// Ports:
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_idx   write word index
//   i_wr_data  write data
//   i_rd_en    read enable; o_rd_data updates only when set
//   i_rd_idx   read word index
//   o_rd_data  registered read data
module nano_imem_ram
    import nano_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_idx,
    input  logic [FETCH_W-1:0] i_wr_data,
    input  logic               i_rd_en,
    input  logic [AW-1:0]      i_rd_idx,
    output logic [FETCH_W-1:0] o_rd_data
);

    logic [FETCH_W-1:0] mem [DEPTH];

    // Non-blocking read of mem gives read-before-write on a same-word collision.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_idx] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= mem[i_rd_idx];
        end
    end

endmodule

// File: rtl/nano_imem.sv
// nano_imem: instruction-fetch responder for the nano_riscv core.
//   Accepts one fetch at a time on the request channel and returns the
//   instruction word (or NOP with o_rsp_err on a misaligned / out-of-range
//   fetch) on the response channel. The loader write port is live in every
//   state; out-of-range loader writes are dropped.
// Configuration macro: NANO_IMEM_WAIT_EN
//   defined   - LATENCY wait states between acceptance and the array read
//   undefined - no wait counter; fixed one-cycle latency, LATENCY ignored
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_req_valid/o_req_ready   fetch request handshake
//   i_req_addr                fetch byte address
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_inst, o_rsp_err     response payload
//   i_wr_en/i_wr_addr/i_wr_data  loader write port (addr bits [1:0] ignored)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; accept latches index and error flag
// WAIT  | counting down wait states (NANO_IMEM_WAIT_EN builds only)
// RESP  | array read launched on entry; response held until taken
module nano_imem
    import nano_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [31:0]        i_req_addr,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [FETCH_W-1:0] o_rsp_inst,
    output logic               o_rsp_err,
    input  logic               i_wr_en,
    input  logic [31:0]        i_wr_addr,
    input  logic [FETCH_W-1:0] i_wr_data
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 4 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("nano_imem: DEPTH must be a power of two in 4..4096");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("nano_imem: LATENCY must be in 0..15");
    end

    imem_state_e        state;
    logic [AW-1:0]      idx_q;
    logic               err_q;
    logic               rd_pend;

    logic               accept;
    logic               req_err;
    logic               rd_en;
    logic [AW-1:0]      rd_idx;
    logic [FETCH_W-1:0] ram_rdata;
    logic               wr_ok;
    logic               unused_wr_lsb;

`ifdef NANO_IMEM_WAIT_EN
    logic [3:0]         cnt;
`endif

    assign accept  = (state == IDLE) && i_req_valid && o_req_ready;
    assign req_err = (i_req_addr[1:0] != 2'b00) || (|i_req_addr[31:AW+2]);
    assign wr_ok   = i_wr_en && !(|i_wr_addr[31:AW+2]);

    assign unused_wr_lsb = &{1'b0, i_wr_addr[1:0]};

    // The array is read on the edge that enters RESP. On a direct IDLE->RESP
    // transition the index is not latched yet, so it comes from the request.
`ifdef NANO_IMEM_WAIT_EN
    assign rd_en = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd1));
`else
    assign rd_en = accept;
`endif
    assign rd_idx = (state == IDLE) ? i_req_addr[AW+1:2] : idx_q;

    nano_imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (wr_ok),
        .i_wr_idx  (i_wr_addr[AW+1:2]),
        .i_wr_data (i_wr_data),
        .i_rd_en   (rd_en),
        .i_rd_idx  (rd_idx),
        .o_rd_data (ram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_inst  <= '0;
            o_rsp_err   <= 1'b0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            rd_pend     <= 1'b0;
`ifdef NANO_IMEM_WAIT_EN
            cnt         <= '0;
`endif
        end else begin
            // Read data lands one edge after the array read; present it then.
            rd_pend <= rd_en;
            if (rd_pend) begin
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= err_q;
                o_rsp_inst  <= err_q ? NOP_INST : ram_rdata;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        idx_q       <= i_req_addr[AW+1:2];
                        err_q       <= req_err;
                        o_req_ready <= 1'b0;
`ifdef NANO_IMEM_WAIT_EN
                        cnt         <= 4'(LATENCY);
                        state       <= (LATENCY == 0) ? RESP : WAIT;
`else
                        state       <= RESP;
`endif
                    end else begin
                        o_req_ready <= 1'b1;
                    end
                end
`ifdef NANO_IMEM_WAIT_EN
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
`endif
                RESP: begin
                    if (o_rsp_valid && i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
